hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 119 +++++++++++
 tb/tb_hazard_controller.sv | 95 +++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush control with mul/div and memory waits.
// Optional HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter on stall_cycles.
module hazard_controller #(
  parameter int WDOG_MAX = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        idex_mdu,
  input  logic        mdu_done,
  input  logic        ex_branch_taken,
  input  logic        exmem_memreq,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        mdu_go,
  output logic        timeout_err,
  output logic [1:0]  state_dbg,
  output logic [31:0] stall_cycles
);
  localparam logic [1:0] RUN = 2'd0, MDU_WAIT = 2'd1, MEM_WAIT = 2'd2;
  localparam int WW = $clog2(WDOG_MAX + 1);
  logic [1:0] state, state_nx;
  logic [WW-1:0] wd;
  logic load_use, mem_stall, wd_hit, wd_fire;
  assign load_use  = idex_memread && idex_rd != 5'd0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
  assign mem_stall = exmem_memreq && !dmem_ready;
  assign wd_hit    = wd == WW'(WDOG_MAX - 1);
  assign state_dbg = state;
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mdu_go      = 1'b0;
    wd_fire     = 1'b0;
    state_nx    = state;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
      state_nx = RUN;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            state_nx = MEM_WAIT;
          end else if (idex_mdu) begin
            {pc_en, ifid_en, idex_en} = 3'b0;
            exmem_flush = 1'b1;
            mdu_go      = 1'b1;
            state_nx    = MDU_WAIT;
          end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MDU_WAIT: begin
          if (!mdu_done) begin
            {pc_en, ifid_en, idex_en} = 3'b0;
            exmem_flush = 1'b1;
            wd_fire     = wd_hit;
          end
          state_nx = (mdu_done || wd_hit) ? RUN : MDU_WAIT;
        end
        MEM_WAIT: begin
          if (!dmem_ready) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            wd_fire = wd_hit;
          end else begin
            // a branch held during the freeze resolves on the release cycle
            ifid_flush = ex_branch_taken;
            idex_flush = ex_branch_taken;
          end
          state_nx = (dmem_ready || wd_hit) ? RUN : MEM_WAIT;
        end
        default: state_nx = RUN;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      wd          <= (state == RUN) ? '0 : wd + 1'b1;
      timeout_err <= timeout_err | wd_fire;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (!pc_en && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
  end
  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scoreboard bench for hazard_controller (WDOG_MAX=8).
module tb_hazard_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic idex_memread = 0, idex_mdu = 0, mdu_done = 0, ex_branch_taken = 0, exmem_memreq = 0, dmem_ready = 0;
  logic [4:0] idex_rd = 0, ifid_rs1 = 0, ifid_rs2 = 0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, mdu_go, timeout_err;
  logic [1:0] state_dbg;
  logic [31:0] stall_cycles;
  hazard_controller #(.WDOG_MAX(8)) dut (
    .clk(clk), .rst(rst), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_mdu(idex_mdu), .mdu_done(mdu_done),
    .ex_branch_taken(ex_branch_taken), .exmem_memreq(exmem_memreq), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .mdu_go(mdu_go),
    .timeout_err(timeout_err), .state_dbg(state_dbg), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  // {pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl,exmem_fl, mdu_go, timeout_err, state}
  localparam logic [11:0] RSTV = 12'b000001110000, IDLE = 12'b111110000000, LU = 12'b001110100000,
    BR = 12'b111111100000, GO = 12'b000110011000, MW = 12'b000110010001, MDONE = 12'b111110000001,
    MF0 = 12'b000000000000, MF = 12'b000000000010, MREL_BR = 12'b111111100010, TO_IDLE = 12'b111110000100;
  int total = 0, bad = 0, exp_stall = 0;
  logic [11:0] exp_q[$];
  string tag_q[$];
  wire [11:0] obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
                     mdu_go, timeout_err, state_dbg};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, 32'(obs), 32'(e));
      if (rst) exp_stall = 0;
`ifdef HAZARD_PERF_CNT_EN
      chk({t, "_stall"}, stall_cycles, 32'(exp_stall));
      if (!rst && !e[11]) exp_stall++;
`else
      chk({t, "_stall"}, stall_cycles, 32'd0);
`endif
    end
  end
  task automatic cyc(input string tag, input logic r, input logic mr, input logic [4:0] rd, rs1, rs2,
                     input logic mdu, done, br, mreq, rdy, input logic [11:0] e);
    @(posedge clk);
    #1;
    rst = r; idex_memread = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
    idex_mdu = mdu; mdu_done = done; ex_branch_taken = br; exmem_memreq = mreq; dmem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask
  initial begin
    cyc("reset",       1, 0, 0, 0, 0, 1, 0, 0, 0, 0, RSTV);
    cyc("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    cyc("lu_rs2",      0, 1, 5, 0, 5, 0, 0, 0, 0, 0, LU);
    cyc("lu_after",    0, 0, 5, 0, 5, 0, 0, 0, 0, 0, IDLE);
    cyc("lu_rs1",      0, 1, 7, 7, 3, 0, 0, 0, 0, 0, LU);
    cyc("lu_rd0",      0, 1, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    cyc("lu_nomatch",  0, 1, 9, 8, 10, 0, 0, 0, 0, 0, IDLE);
    cyc("br_lu",       0, 1, 5, 5, 0, 0, 0, 1, 0, 0, BR);
    cyc("mdu_go",      0, 0, 0, 0, 0, 1, 0, 0, 0, 0, GO);
    for (int i = 0; i < 4; i++) cyc("mdu_wait", 0, 0, 0, 0, 0, 0, 0, i == 1, 0, 0, MW);
    cyc("mdu_done",    0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MDONE);
    cyc("mdu_back",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    cyc("run_ignore",  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, IDLE);
    cyc("mem_ready",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE);
    cyc("mem_frz0",    0, 0, 0, 0, 0, 1, 0, 1, 1, 0, MF0);
    cyc("mem_frz1",    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, MF);
    cyc("mem_frz2",    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, MF);
    cyc("mem_rel_br",  0, 0, 0, 0, 0, 0, 0, 1, 1, 1, MREL_BR);
    cyc("mem_back",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    cyc("abort_frz",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MF0);
    cyc("abort_wait",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MF);
    cyc("abort_rst",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, RSTV);
    cyc("abort_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    cyc("wd_go",       0, 0, 0, 0, 0, 1, 0, 0, 0, 0, GO);
    for (int i = 0; i < 8; i++) cyc("wd_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MW);
    cyc("wd_timeout",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TO_IDLE);
    cyc("wd_sticky",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TO_IDLE);
    cyc("wd_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV);
    cyc("wd_cleared",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
